// File: rtl/alu_8bit_if.sv
// Operand/function bus into the ALU and registered result/carry back out.
// The master drives operands every cycle; there is no handshake or backpressure.
interface alu_8bit_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       ALU_Sel;
  logic [WIDTH-1:0] ALU_Out;
  logic             CarryOut;

  modport master (
    output A, B, ALU_Sel,
    input  ALU_Out, CarryOut
  );

  modport slave (
    input  A, B, ALU_Sel,
    output ALU_Out, CarryOut
  );
endinterface

// File: rtl/alu_8bit.sv
// 16-function unsigned ALU, 1-cycle registered result plus A+B carry.
// Accepts new operands every cycle; no backpressure, sync active-high reset.
module alu_8bit #(
  parameter int WIDTH = 8
) (
  input logic        clk,
  input logic        rst,
  alu_8bit_if.slave  alu_bus
);

  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [WIDTH:0]     sum_ext;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   alu_out_d, alu_out_q;
  logic               carry_d, carry_q;

  assign a       = alu_bus.A;
  assign b       = alu_bus.B;
  assign sum_ext = {1'b0, a} + {1'b0, b};
  assign prod    = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
  // Divide by zero saturates to all ones instead of flagging an error.
  assign quot    = (b == '0) ? '1 : (a / b);

  always_comb begin
    alu_out_d = '0;
    carry_d   = sum_ext[WIDTH];
    case (alu_bus.ALU_Sel)
      4'h0: alu_out_d = sum_ext[WIDTH-1:0];
      4'h1: alu_out_d = a - b;
      4'h2: alu_out_d = prod[WIDTH-1:0];
      4'h3: alu_out_d = quot;
      4'h4: alu_out_d = {a[WIDTH-2:0], 1'b0};
      4'h5: alu_out_d = {1'b0, a[WIDTH-1:1]};
      4'h6: alu_out_d = {a[WIDTH-2:0], a[WIDTH-1]};
      4'h7: alu_out_d = {a[0], a[WIDTH-1:1]};
      4'h8: alu_out_d = a & b;
      4'h9: alu_out_d = a | b;
      4'hA: alu_out_d = a ^ b;
      4'hB: alu_out_d = ~(a | b);
      4'hC: alu_out_d = ~(a & b);
      4'hD: alu_out_d = ~(a ^ b);
      4'hE: alu_out_d = (a > b)  ? WIDTH'(1) : '0;
      4'hF: alu_out_d = (a == b) ? WIDTH'(1) : '0;
      default: alu_out_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_out_q <= '0;
      carry_q   <= 1'b0;
    end else begin
      alu_out_q <= alu_out_d;
      carry_q   <= carry_d;
    end
  end

  assign alu_bus.ALU_Out  = alu_out_q;
  assign alu_bus.CarryOut = carry_q;

endmodule

// File: tb/tb_alu_8bit.sv
// Directed-vector bench for alu_8bit: hand-computed results checked one cycle after each edge.
`timescale 1ns/1ps
module tb_alu_8bit;

  logic clk;
  logic rst;
  int   total_cnt;
  int   bad_cnt;

  alu_8bit_if #(.WIDTH(8)) alu_bus ();

  alu_8bit #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .alu_bus (alu_bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%02h exp=%02h", tag, got, exp);
    end
  endtask

  // Drive one vector at the falling edge, then sample just after the rising edge.
  task automatic step(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel,
                      input logic r);
    @(negedge clk);
    alu_bus.A       = a;
    alu_bus.B       = b;
    alu_bus.ALU_Sel = sel;
    rst             = r;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp_sweep [16];
  logic [3:0] sel_v;

  initial begin
    total_cnt = 0;
    bad_cnt   = 0;
    exp_sweep = '{8'h0C, 8'h08, 8'h14, 8'h05, 8'h14, 8'h05, 8'h14, 8'h05,
                  8'h02, 8'h0A, 8'h08, 8'hF5, 8'hFD, 8'hF7, 8'h01, 8'h00};
    rst             = 1'b1;
    alu_bus.A       = '0;
    alu_bus.B       = '0;
    alu_bus.ALU_Sel = '0;

    // Reset with random operands present.
    for (int i = 0; i < 2; i++) begin
      step(8'($urandom), 8'($urandom), 4'($urandom), 1'b1);
      check_val("rst_out", alu_bus.ALU_Out, 8'h00);
      check_val("rst_cy", {7'b0, alu_bus.CarryOut}, 8'h00);
    end

    // Full function sweep on 0A/02.
    for (int s = 0; s < 16; s++) begin
      step(8'h0A, 8'h02, 4'(s), 1'b0);
      check_val($sformatf("sweep_%0h", s), alu_bus.ALU_Out, exp_sweep[s]);
      check_val($sformatf("sweep_cy_%0h", s), {7'b0, alu_bus.CarryOut}, 8'h00);
    end

    // Carry-out and wrap cases on F6/0A.
    step(8'hF6, 8'h0A, 4'h0, 1'b0);
    check_val("add_wrap", alu_bus.ALU_Out, 8'h00);
    check_val("add_cy", {7'b0, alu_bus.CarryOut}, 8'h01);
    step(8'hF6, 8'h0A, 4'h1, 1'b0);
    check_val("sub_f6", alu_bus.ALU_Out, 8'hEC);
    check_val("sub_cy", {7'b0, alu_bus.CarryOut}, 8'h01);
    step(8'hF6, 8'h0A, 4'h6, 1'b0);
    check_val("rol_f6", alu_bus.ALU_Out, 8'hED);
    check_val("rol_cy", {7'b0, alu_bus.CarryOut}, 8'h01);
    step(8'hF6, 8'h0A, 4'h7, 1'b0);
    check_val("ror_f6", alu_bus.ALU_Out, 8'h7B);
    check_val("ror_cy", {7'b0, alu_bus.CarryOut}, 8'h01);

    // Divide by zero, multiply overflow, compares on equal operands.
    step(8'h10, 8'h00, 4'h3, 1'b0);
    check_val("div_zero", alu_bus.ALU_Out, 8'hFF);
    check_val("div_zero_cy", {7'b0, alu_bus.CarryOut}, 8'h00);
    step(8'hFF, 8'hFF, 4'h2, 1'b0);
    check_val("mul_ff", alu_bus.ALU_Out, 8'h01);
    check_val("mul_ff_cy", {7'b0, alu_bus.CarryOut}, 8'h01);
    step(8'hFF, 8'hFF, 4'hF, 1'b0);
    check_val("eq_ff", alu_bus.ALU_Out, 8'h01);
    step(8'hFF, 8'hFF, 4'hE, 1'b0);
    check_val("gt_ff", alu_bus.ALU_Out, 8'h00);
    step(8'h80, 8'h7F, 4'hE, 1'b0);
    check_val("gt_unsigned", alu_bus.ALU_Out, 8'h01);

    // Select wraps from F to 0: add result follows.
    sel_v = 4'hF;
    step(8'h03, 8'h03, sel_v, 1'b0);
    check_val("wrap_eq", alu_bus.ALU_Out, 8'h01);
    sel_v = sel_v + 4'h1;
    step(8'h03, 8'h03, sel_v, 1'b0);
    check_val("wrap_add", alu_bus.ALU_Out, 8'h06);

    // Outputs hold while inputs change between edges.
    #2;
    alu_bus.A       = 8'h55;
    alu_bus.B       = 8'hAA;
    alu_bus.ALU_Sel = 4'h9;
    #1;
    check_val("hold_out", alu_bus.ALU_Out, 8'h06);

    // Reset mid-sweep: zero for one cycle, then resume with fresh results.
    for (int s = 0; s < 6; s++) begin
      step(8'h0A, 8'h02, 4'(s), 1'b0);
      check_val($sformatf("pre_rst_%0h", s), alu_bus.ALU_Out, exp_sweep[s]);
    end
    step(8'hF6, 8'h0A, 4'h6, 1'b1);
    check_val("mid_rst_out", alu_bus.ALU_Out, 8'h00);
    check_val("mid_rst_cy", {7'b0, alu_bus.CarryOut}, 8'h00);
    for (int s = 6; s < 16; s++) begin
      step(8'h0A, 8'h02, 4'(s), 1'b0);
      check_val($sformatf("post_rst_%0h", s), alu_bus.ALU_Out, exp_sweep[s]);
    end

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
